cmd_decoder: RTL and testbench

//  Downstream of the packet assembler. Consumes validated packets (SYNC, LEN, OPCODE, ARGS.., CRC),

---
 rtl/cmd_decoder.sv | 164 ++++++++++++++++
 tb/tb_cmd_decoder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_decoder.sv
// cmd_decoder: checks validated packets against a fixed opcode table and serialises each
// legal command as a header word plus big-endian argument words on a valid/ready stream.
// Latency: valid_packet to first cmd_valid is 1 cycle; 1 word/cycle while cmd_ready is high.
// Backpressure: words hold stable while cmd_ready is low; packets arriving while busy are dropped.
//
// Ports:
//   CLK, rst                 clock and synchronous active-high reset
//   packet, packet_len       packet bytes (byte k = packet[8k+:8]) and total length incl. SYNC/LEN/CRC
//   valid_packet             1-cycle strobe qualifying packet/packet_len
//   cmd_data/valid/ready/last  32-bit command word stream
//   busy                     a command is in flight
//   err_op, err_overrun      1-cycle error pulses (illegal packet / packet dropped while busy)
//   stat_cmds, stat_errs     16-bit event counters, built only when CMD_STATS_EN is defined
module cmd_decoder #(
  parameter int SIZE    = 256,
  parameter int MAX_ARG = 16
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [8*SIZE-1:0] packet,
  input  logic              valid_packet,
  input  logic [8:0]        packet_len,
  output logic [31:0]       cmd_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_last,
  output logic              busy,
  output logic              err_op,
  output logic              err_overrun,
  output logic [15:0]       stat_cmds,
  output logic [15:0]       stat_errs
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_ARGS} state_t;

  state_t               r_state, w_next;
  logic [7:0]           r_opcode;
  logic [8:0]           r_argc;
  logic [7:0]           r_nwords;
  logic [7:0]           r_widx;
  logic [8*MAX_ARG-1:0] r_args;
  logic                 r_err_op;
  logic                 r_err_overrun;

  logic [7:0]  w_op;
  logic [8:0]  w_argc;
  logic [8:0]  w_nw9;
  logic        w_legal;
  logic        w_accept;
  logic        w_hs;
  logic [31:0] w_word;
  logic        w_unused;

  assign w_op     = packet[23:16];
  assign w_argc   = packet_len - 9'd4;
  assign w_nw9    = (w_argc + 9'd3) >> 2;
  assign w_hs     = cmd_valid && cmd_ready;
  assign w_accept = valid_packet && (r_state == S_IDLE) && w_legal;
  // SYNC/LEN bytes, bytes beyond the shadow window and the top nwords bit are not needed.
  assign w_unused = ^{packet[15:0], packet[8*SIZE-1:8*(3+MAX_ARG)], w_nw9[8]};

  always_comb begin
    w_legal = 1'b0;
    case (w_op)
      8'h01:   w_legal = (w_argc == 9'd2);
      8'h02:   w_legal = (w_argc == 9'd6);
      8'h03:   w_legal = (w_argc == 9'd10);
      8'h04:   w_legal = (w_argc == 9'd10);
      8'h05:   w_legal = (w_argc == 9'd0);
      default: w_legal = 1'b0;
    endcase
    // packet_len < 4 wraps argc to a large value; reject it explicitly anyway.
    if (packet_len < 9'd4) w_legal = 1'b0;
  end

  // Argument word r_widx; shadow bytes past argc hold CRC/bus junk and are masked to zero.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < MAX_ARG; k++) begin
      if ((k / 4 == int'(r_widx)) && (k < int'(r_argc)))
        w_word[31-8*(k%4) -: 8] = r_args[8*k +: 8];
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    cmd_data  = '0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_HDR;
      end
      S_HDR: begin
        busy      = 1'b1;
        cmd_valid = 1'b1;
        cmd_data  = {r_opcode, r_argc[7:0], r_nwords, 8'h00};
        cmd_last  = (r_nwords == 8'd0);
        if (w_hs) w_next = (r_nwords == 8'd0) ? S_IDLE : S_ARGS;
      end
      S_ARGS: begin
        busy      = 1'b1;
        cmd_valid = 1'b1;
        cmd_data  = w_word;
        cmd_last  = (r_widx == r_nwords - 8'd1);
        if (w_hs && cmd_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_opcode      <= '0;
      r_argc        <= '0;
      r_nwords      <= '0;
      r_widx        <= '0;
      r_args        <= '0;
      r_err_op      <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_err_op      <= valid_packet && !busy && !w_legal;
      // busy is still high on the last handshake cycle, so a packet there is dropped too.
      r_err_overrun <= valid_packet && busy;
      if (w_accept) begin
        r_opcode <= w_op;
        r_argc   <= w_argc;
        r_nwords <= w_nw9[7:0];
        r_args   <= packet[8*3 +: 8*MAX_ARG];
        r_widx   <= '0;
      end else if ((r_state == S_ARGS) && w_hs) begin
        r_widx <= r_widx + 8'd1;
      end
    end
  end

  assign err_op      = r_err_op;
  assign err_overrun = r_err_overrun;

`ifdef CMD_STATS_EN
  logic [15:0] r_stat_cmds;
  logic [15:0] r_stat_errs;

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_stat_cmds <= '0;
      r_stat_errs <= '0;
    end else begin
      if (w_hs && cmd_last) r_stat_cmds <= r_stat_cmds + 16'd1;
      r_stat_errs <= r_stat_errs + {15'd0, r_err_op} + {15'd0, r_err_overrun};
    end
  end

  assign stat_cmds = r_stat_cmds;
  assign stat_errs = r_stat_errs;
`else
  assign stat_cmds = '0;
  assign stat_errs = '0;
`endif

endmodule

// File: tb/tb_cmd_decoder.sv
// tb_cmd_decoder: scoreboard bench for cmd_decoder; expected words are queued when a
// packet is driven and compared as the DUT hands words over.
`timescale 1ns/1ps
module tb_cmd_decoder;
  localparam int SIZE = 256;
`ifdef CMD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              rst;
  logic [8*SIZE-1:0] packet;
  logic              valid_packet;
  logic [8:0]        packet_len;
  logic [31:0]       cmd_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_last;
  logic              busy;
  logic              err_op;
  logic              err_overrun;
  logic [15:0]       stat_cmds;
  logic [15:0]       stat_errs;

  logic rdy_man = 1'b0;
  logic tog_en  = 1'b0;
  logic tog     = 1'b0;
  assign cmd_ready = tog_en ? tog : rdy_man;

  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    #1 tog = ~tog;
  end

  cmd_decoder #(.SIZE(SIZE), .MAX_ARG(16)) dut (
    .CLK          (CLK),
    .rst          (rst),
    .packet       (packet),
    .valid_packet (valid_packet),
    .packet_len   (packet_len),
    .cmd_data     (cmd_data),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_last     (cmd_last),
    .busy         (busy),
    .err_op       (err_op),
    .err_overrun  (err_overrun),
    .stat_cmds    (stat_cmds),
    .stat_errs    (stat_errs)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] sb[$];
  int          busy_cnt = 0;
  int          exp_cmds = 0;
  int          exp_errs = 0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: compares each transferred word against the scoreboard and checks stall stability.
  always @(negedge CLK) begin
    logic [32:0] w;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (prev_stall)
        check("stall_hold", {30'd0, cmd_valid, cmd_last, cmd_data}, {30'd0, 1'b1, prev_word});
      if (cmd_valid && cmd_ready) begin
        if (sb.size() == 0) begin
          check("extra_word_sb_depth", 64'(sb.size()), 64'd1);
        end else begin
          w = sb.pop_front();
          check("word", {31'd0, cmd_last, cmd_data}, {31'd0, w});
          if (w[32]) exp_cmds++;
        end
      end
      prev_stall = cmd_valid && !cmd_ready;
      prev_word  = {cmd_last, cmd_data};
    end
  end

  task automatic randomize_bus();
    for (int k = 0; k < SIZE; k++) packet[8*k +: 8] = 8'($urandom);
  endtask

  // Drives one packet starting now (caller is just after a rising edge); queues the
  // expected words if the packet is legal and not expected to be dropped.
  task automatic send_pkt(input logic [7:0] op, input int plen, input logic [127:0] av, input bit drop);
    int argc, nw, req;
    bit ok;
    logic [31:0] w;
    argc = plen - 4;
    case (op)
      8'h01:   req = 2;
      8'h02:   req = 6;
      8'h03:   req = 10;
      8'h04:   req = 10;
      8'h05:   req = 0;
      default: req = -1;
    endcase
    ok = (plen >= 4) && (argc == req);
    randomize_bus();
    packet[7:0]   = 8'hA5;
    packet[15:8]  = 8'(plen - 2);
    packet[23:16] = op;
    for (int i = 0; i < argc && i < 16; i++) packet[8*(3+i) +: 8] = av[127-8*i -: 8];
    if (ok && !drop) begin
      nw = (argc + 3) / 4;
      sb.push_back({(nw == 0), op, 8'(argc), 8'(nw), 8'h00});
      for (int j = 0; j < nw; j++) begin
        w = '0;
        for (int b = 0; b < 4; b++)
          if (4*j + b < argc) w[31-8*b -: 8] = av[127-8*(4*j+b) -: 8];
        sb.push_back({(j == nw - 1), w});
      end
    end
    valid_packet = 1'b1;
    packet_len   = 9'(plen);
    @(posedge CLK);
    #1;
    valid_packet = 1'b0;
    randomize_bus();
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((sb.size() != 0 || cmd_valid) && t < 300) begin
      @(negedge CLK);
      t++;
    end
    check({tag, "_drain"}, 64'(t < 300), 64'd1);
    @(negedge CLK);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bad_op [3];
    int         bad_len [3];
    bad_op  = '{8'h07, 8'h01, 8'h05};
    bad_len = '{6, 7, 3};

    rst = 1'b1; valid_packet = 1'b0; packet = '0; packet_len = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_data",  64'(cmd_data), 64'd0);
    check("rst_last",  64'(cmd_last), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_err_op", 64'(err_op), 64'd0);
    check("rst_err_ovr", 64'(err_overrun), 64'd0);
    check("rst_stat_cmds", 64'(stat_cmds), 64'd0);
    check("rst_stat_errs", 64'(stat_errs), 64'd0);
    step();
    rst = 1'b0;

    // PIXEL, ready held high.
    rdy_man = 1'b1;
    step();
    busy_cnt = 0;
    send_pkt(8'h02, 10, 128'h00100020_F8000000_00000000_00000000, 1'b0);
    @(negedge CLK);
    check("pixel_latency", 64'(cmd_valid), 64'd1);
    drain("pixel");
    check("pixel_busy_cycles", 64'(busy_cnt), 64'd3);

    // FRAME_SYNC: header only, last on the header.
    step();
    busy_cnt = 0;
    send_pkt(8'h05, 4, 128'h0, 1'b0);
    @(negedge CLK);
    check("fsync_valid", 64'(cmd_valid), 64'd1);
    check("fsync_last",  64'(cmd_last), 64'd1);
    drain("fsync");
    check("fsync_busy_cycles", 64'(busy_cnt), 64'd1);

    // LINE with ready toggling every cycle.
    tog_en = 1'b1;
    step();
    send_pkt(8'h03, 14, 128'h11223344_55667788_99AA0000_00000000, 1'b0);
    @(negedge CLK);
    check("line_latency", 64'(cmd_valid), 64'd1);
    drain("line");
    tog_en = 1'b0;

    // Illegal packets: unknown opcode, wrong argc, too short.
    for (int i = 0; i < 3; i++) begin
      step();
      send_pkt(bad_op[i], bad_len[i], 128'hDEADBEEF_01020304_05060708_090A0B0C, 1'b0);
      @(negedge CLK);
      check("bad_err_op", 64'(err_op), 64'd1);
      check("bad_no_valid", 64'(cmd_valid), 64'd0);
      check("bad_no_busy", 64'(busy), 64'd0);
      @(negedge CLK);
      check("bad_err_op_pulse", 64'(err_op), 64'd0);
      check("bad_no_valid2", 64'(cmd_valid), 64'd0);
      exp_errs++;
    end

    // Overrun one cycle after RECT_FILL is accepted, downstream stalled.
    rdy_man = 1'b0;
    step();
    send_pkt(8'h04, 14, 128'hA1A2A3A4_B1B2B3B4_C1C20000_00000000, 1'b0);
    send_pkt(8'h02, 10, 128'h01010101_02020000_00000000_00000000, 1'b1);
    @(negedge CLK);
    check("ovr_pulse", 64'(err_overrun), 64'd1);
    check("ovr_no_err_op", 64'(err_op), 64'd0);
    check("ovr_busy", 64'(busy), 64'd1);
    @(negedge CLK);
    check("ovr_pulse_end", 64'(err_overrun), 64'd0);
    exp_errs++;
    step();
    rdy_man = 1'b1;
    drain("rect");

    // Packet on the cycle of the final handshake is also dropped.
    step();
    send_pkt(8'h05, 4, 128'h0, 1'b0);
    send_pkt(8'h02, 10, 128'h01010101_02020000_00000000_00000000, 1'b1);
    @(negedge CLK);
    check("ovr_last_pulse", 64'(err_overrun), 64'd1);
    check("ovr_last_idle", 64'(cmd_valid), 64'd0);
    exp_errs++;
    drain("ovr_last");

    check("stat_cmds", 64'(stat_cmds), STATS ? 64'(exp_cmds) : 64'd0);
    check("stat_errs", 64'(stat_errs), STATS ? 64'(exp_errs) : 64'd0);

    // Reset while stalled in ARGS.
    step();
    send_pkt(8'h03, 14, 128'h0F0E0D0C_0B0A0908_07060000_00000000, 1'b0);
    step();
    rdy_man = 1'b0;
    @(negedge CLK);
    check("pre_rst_busy", 64'(busy), 64'd1);
    step();
    rst = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("mid_rst_valid", 64'(cmd_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_stat_cmds", 64'(stat_cmds), 64'd0);
    check("mid_rst_stat_errs", 64'(stat_errs), 64'd0);
    step();
    rst = 1'b0;
    sb.delete();
    exp_cmds = 0;
    exp_errs = 0;

    // Recovery after reset.
    rdy_man = 1'b1;
    step();
    send_pkt(8'h01, 6, 128'h55AA0000_00000000_00000000_00000000, 1'b0);
    drain("post_rst");
    check("post_rst_stat_cmds", 64'(stat_cmds), STATS ? 64'(exp_cmds) : 64'd0);
    check("sb_empty_end", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
